wb_regfile_stage: RTL and testbench
===================================

Name: wb_regfile_stage

Overview:
Writeback stage of the RV32 core; sits directly downstream of the memory stage and consumes its sign/zero-extended load data plus the ALU result.
- Selects the writeback value and registers it in a one-entry writeback buffer, which cuts the combinational path from the DPI memory read.
- Commits the buffered value to the 32-entry architectural register file one cycle later.
- Serves two combinational read ports to decode/execute, with forwarding from the pending buffer entry.

Parameters:
XLEN, 32, data width of registers and datapath
REG_NUM, 32, number of architectural registers; index width is clog2(REG_NUM)

Ports:
clk  input  1  core clock; all state updates on posedge
rst  input  1  asynchronous, active-low reset (asserted when 0)
wb_valid_i  input  1  an instruction retires this cycle
rd_we_i  input  1  instruction writes rd
rd_addr_i  input  5  destination register index
wb_sel_i  input  2  writeback source: 00 ALU, 01 memory, 10 pc+4, 11 immediate
alu_result_i  input  XLEN  ALU result from execute
mem_read_data_i  input  XLEN  extended load data from the memory stage
pc_i  input  XLEN  pc of the retiring instruction
imm_i  input  XLEN  immediate (LUI)
rs1_addr_i  input  5  read port 1 index
rs2_addr_i  input  5  read port 2 index
rs1_data_o  output  XLEN  read port 1 data
rs2_data_o  output  XLEN  read port 2 data
commit_valid_o  output  1  a register-file write happens at the next posedge
commit_rd_o  output  5  index being committed
commit_data_o  output  XLEN  value being committed
cycle_cnt_o  output  64  cycle counter (optional feature)
instret_cnt_o  output  64  retired-instruction counter (optional feature)

Behaviour:
- Writeback value selection (combinational): sel 00 gives alu_result_i; 01 gives mem_read_data_i; 10 gives pc_i+4 (mod 2^32, wraps); 11 gives imm_i.
- Buffer capture at posedge:
  - pend_valid <= wb_valid_i & rd_we_i & (rd_addr_i != 0).
  - pend_rd and pend_data are captured when wb_valid_i=1 and hold otherwise.
- Commit: at posedge, if pend_valid, regs[pend_rd] <= pend_data. Capture and commit happen at the same edge without conflict.
- Latency: value selected in cycle N is buffered at end of N and lands in the register file at end of N+1.
- commit_valid_o, commit_rd_o and commit_data_o equal pend_valid, pend_rd and pend_data (registered outputs, no combinational input path).
- Read ports, combinational, evaluated in priority order:
  - index 0 returns 0;
  - else, if pend_valid and pend_rd matches the index, return pend_data (forward);
  - else return regs[index].
- x0: never written. The rd=0 case is filtered at capture, and regs[0] is read as constant 0.
- Back-to-back writes to the same rd: the newer value is in the buffer and is forwarded; the older value commits to the array at the same edge and is shadowed by the forward. Reads never return a stale value.
- wb_valid_i=1 with rd_we_i=0 (store/branch): no buffer write, pend_valid becomes 0, and the instruction still counts as retired.
- Reset (rst=0, asynchronous):
  - all regs, pend_valid, pend_rd, pend_data and both counters go to 0;
  - commit_valid_o=0;
  - a pending write at reset time is discarded.
  - Reads during reset return 0.
- Inputs are sampled on the first posedge after rst deasserts.

Optional Feature:
Macro WB_PERF_CNT_EN.
- Defined: 64-bit cycle_cnt_o increments every posedge out of reset. instret_cnt_o increments on each posedge with wb_valid_i=1. Both wrap at 2^64.
- Undefined: the counter registers are not built, and both ports are tied to 0. The ports remain present so the interface is unchanged.

Decomposition:
- Shared package core_pkg:
  - XLEN;
  - a REG_IDX_W=5 constant;
  - the wb_sel enum (WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_PC4=2'b10, WB_SEL_IMM=2'b11).
- One natural sub-module, regfile_2r1w: a storage array with async reset, one write port and two raw read ports. The stage wraps it with the buffer, forwarding muxes and counters.

Test Plan:
- Reset then read: rst=0 for 2 cycles then 1; rs1=5, rs2=31 -> both data 0; commit_valid_o=0.
- ALU write and forward: cycle N wb_valid=1, we=1, rd=3, sel=00, alu=0xDEADBEEF. In N+1, rs1=3 -> 0xDEADBEEF via forward and commit_valid_o=1. In N+2 (no new write), rs1=3 -> 0xDEADBEEF from the array.
- x0 protection: rd=0, alu=0x12345678 -> commit_valid_o stays 0; rs1=0 -> 0 in all following cycles.
- Source select and back-to-back: rd=7 sel=01 mem=0xFFFFFF80, then next cycle rd=7 sel=10 pc=0xFFFFFFFC. rs2=7 reads 0xFFFFFF80, then 0x00000000 (pc+4 wraps), then 0x00000000 steady.
- Reset mid-operation: buffer holds rd=9/0xA5A5A5A5; assert rst between edges -> rs1=9 reads 0 immediately; after release, still 0.
- WB_PERF_CNT_EN: 10 cycles out of reset with 4 wb_valid pulses (one a store with we=0) -> cycle_cnt_o=10, instret_cnt_o=4. With the macro undefined, both read 0.

Source files
------------

// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
//
// Shared definitions for the RV32 core pipeline stages.
//
// Contents:
//   XLEN       - datapath / register width
//   REG_IDX_W  - architectural register index width
//   wb_sel_e   - writeback source selector encoding
//   pc_plus4   - link-address helper (wraps modulo 2^XLEN)
// ----------------------------------------------------------------------------
package core_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'b00,
        WB_SEL_MEM = 2'b01,
        WB_SEL_PC4 = 2'b10,
        WB_SEL_IMM = 2'b11
    } wb_sel_e;

    // Link address of a retiring jump; the carry out is deliberately dropped
    // so that a pc at the top of the address space wraps to zero.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage : core_pkg

// File: rtl/regfile_2r1w.sv
// ----------------------------------------------------------------------------
// regfile_2r1w
//
// Architectural register storage: REG_NUM entries of XLEN bits, one
// synchronous write port and two raw combinational read ports. Entry 0 is
// hard-wired to zero and has no storage; writes addressed to it are ignored.
// All entries clear asynchronously while rst is low.
//
// Ports:
//   clk             - clock, writes land on posedge
//   rst             - asynchronous reset, active low
//   we_i            - write enable
//   waddr_i/wdata_i - write index / data
//   raddr1_i/raddr2_i - read indices
//   rdata1_o/rdata2_o - raw array contents (no forwarding)
// ----------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int IDX_W   = $clog2(REG_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [IDX_W-1:0] raddr1_i,
    input  logic [IDX_W-1:0] raddr2_i,
    output logic [XLEN-1:0]  rdata1_o,
    output logic [XLEN-1:0]  rdata2_o
);

    // Flattened view of every entry so the read muxes can use a variable
    // part-select; each entry drives its own disjoint slice.
    logic [REG_NUM*XLEN-1:0] regs_flat;

    genvar gi;
    generate
        for (gi = 0; gi < REG_NUM; gi++) begin : g_entry
            if (gi == 0) begin : g_zero
                assign regs_flat[gi*XLEN +: XLEN] = '0;
            end else begin : g_store
                logic [XLEN-1:0] entry_q;
                logic [XLEN-1:0] entry_d;

                always_comb begin
                    entry_d = entry_q;
                    if (we_i && (waddr_i == IDX_W'(gi))) begin
                        entry_d = wdata_i;
                    end
                end

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        entry_q <= '0;
                    end else begin
                        entry_q <= entry_d;
                    end
                end

                assign regs_flat[gi*XLEN +: XLEN] = entry_q;
            end
        end
    endgenerate

    assign rdata1_o = regs_flat[raddr1_i*XLEN +: XLEN];
    assign rdata2_o = regs_flat[raddr2_i*XLEN +: XLEN];

endmodule : regfile_2r1w

// File: rtl/wb_regfile_stage.sv
// ----------------------------------------------------------------------------
// wb_regfile_stage
//
// RV32 writeback stage. Selects the writeback value, holds it for one cycle
// in a single-entry writeback buffer (breaking the path from the memory read
// data into the register array), commits it to the register file on the
// following edge, and serves two combinational read ports that forward from
// the buffered entry.
//
// Optional build macro:
//   WB_PERF_CNT_EN - when defined, builds 64-bit cycle and retired-instruction
//                    counters; when undefined both counter ports read zero.
//
// Ports:
//   clk, rst                    - clock; asynchronous active-low reset
//   wb_valid_i, rd_we_i         - instruction retires / writes rd
//   rd_addr_i, wb_sel_i         - destination index, writeback source
//   alu_result_i, mem_read_data_i, pc_i, imm_i - candidate writeback values
//   rs1_addr_i/rs2_addr_i       - read indices
//   rs1_data_o/rs2_data_o       - forwarded read data
//   commit_valid_o/rd_o/data_o  - buffered entry being written to the array
//   cycle_cnt_o, instret_cnt_o  - performance counters
// ----------------------------------------------------------------------------
module wb_regfile_stage
    import core_pkg::*;
#(
    parameter int XLEN    = core_pkg::XLEN,
    parameter int REG_NUM = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_valid_i,
    input  logic                 rd_we_i,
    input  logic [REG_IDX_W-1:0] rd_addr_i,
    input  logic [1:0]           wb_sel_i,
    input  logic [XLEN-1:0]      alu_result_i,
    input  logic [XLEN-1:0]      mem_read_data_i,
    input  logic [XLEN-1:0]      pc_i,
    input  logic [XLEN-1:0]      imm_i,
    input  logic [REG_IDX_W-1:0] rs1_addr_i,
    input  logic [REG_IDX_W-1:0] rs2_addr_i,
    output logic [XLEN-1:0]      rs1_data_o,
    output logic [XLEN-1:0]      rs2_data_o,
    output logic                 commit_valid_o,
    output logic [REG_IDX_W-1:0] commit_rd_o,
    output logic [XLEN-1:0]      commit_data_o,
    output logic [63:0]          cycle_cnt_o,
    output logic [63:0]          instret_cnt_o
);

    localparam int IDX_W = $clog2(REG_NUM);

    // ------------------------------------------------------------------
    // Writeback value selection
    // ------------------------------------------------------------------
    logic [XLEN-1:0] wb_data;

    always_comb begin
        wb_data = alu_result_i;
        case (wb_sel_e'(wb_sel_i))
            WB_SEL_ALU: wb_data = alu_result_i;
            WB_SEL_MEM: wb_data = mem_read_data_i;
            WB_SEL_PC4: wb_data = pc_i + XLEN'(4);
            WB_SEL_IMM: wb_data = imm_i;
            default:    wb_data = alu_result_i;
        endcase
    end

    // ------------------------------------------------------------------
    // Writeback buffer
    // ------------------------------------------------------------------
    logic                 pend_valid_q, pend_valid_d;
    logic [REG_IDX_W-1:0] pend_rd_q,    pend_rd_d;
    logic [XLEN-1:0]      pend_data_q,  pend_data_d;

    always_comb begin
        // Writes to x0 never enter the buffer, so the array never sees them
        // and forwarding never has to special-case rd = 0.
        pend_valid_d = wb_valid_i & rd_we_i & (rd_addr_i != '0);
        pend_rd_d    = pend_rd_q;
        pend_data_d  = pend_data_q;
        if (wb_valid_i) begin
            pend_rd_d   = rd_addr_i;
            pend_data_d = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid_q <= 1'b0;
            pend_rd_q    <= '0;
            pend_data_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_rd_q    <= pend_rd_d;
            pend_data_q  <= pend_data_d;
        end
    end

    assign commit_valid_o = pend_valid_q;
    assign commit_rd_o    = pend_rd_q;
    assign commit_data_o  = pend_data_q;

    // ------------------------------------------------------------------
    // Register array; the buffered entry commits on the same edge that a
    // new entry is captured, so the array is always one write behind.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rf_rdata1;
    logic [XLEN-1:0] rf_rdata2;

    regfile_2r1w #(
        .XLEN    (XLEN),
        .REG_NUM (REG_NUM),
        .IDX_W   (IDX_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_i     (pend_valid_q),
        .waddr_i  (IDX_W'(pend_rd_q)),
        .wdata_i  (pend_data_q),
        .raddr1_i (IDX_W'(rs1_addr_i)),
        .raddr2_i (IDX_W'(rs2_addr_i)),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    // ------------------------------------------------------------------
    // Read ports with forwarding from the buffered entry. The buffer holds
    // the youngest write, so it must win over the array.
    // ------------------------------------------------------------------
    logic [1:0][REG_IDX_W-1:0] rd_idx;
    logic [1:0][XLEN-1:0]      rd_raw;
    logic [1:0][XLEN-1:0]      rd_out;

    assign rd_idx[0] = rs1_addr_i;
    assign rd_idx[1] = rs2_addr_i;
    assign rd_raw[0] = rf_rdata1;
    assign rd_raw[1] = rf_rdata2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rport
            always_comb begin
                rd_out[gi] = '0;
                if (rd_idx[gi] != '0) begin
                    if (pend_valid_q && (pend_rd_q == rd_idx[gi])) begin
                        rd_out[gi] = pend_data_q;
                    end else begin
                        rd_out[gi] = rd_raw[gi];
                    end
                end
            end
        end
    endgenerate

    assign rs1_data_o = rd_out[0];
    assign rs2_data_o = rd_out[1];

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef WB_PERF_CNT_EN
    logic [63:0] cycle_cnt_q,   cycle_cnt_d;
    logic [63:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + 64'd1;
        // Every retiring instruction counts, including stores and branches
        // that never reach the buffer.
        instret_cnt_d = instret_cnt_q + (wb_valid_i ? 64'd1 : 64'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt_o   = cycle_cnt_q;
    assign instret_cnt_o = instret_cnt_q;
`else
    assign cycle_cnt_o   = '0;
    assign instret_cnt_o = '0;
`endif

endmodule : wb_regfile_stage

// File: tb/tb_wb_regfile_stage.sv
// ----------------------------------------------------------------------------
// tb_wb_regfile_stage
//
// Directed and randomized stimulus against an architectural model: the
// model keeps the programmer-visible register values (a retired write is
// visible from the next cycle onward) plus the last captured writeback
// entry and the two counters. Expected observations are queued by the
// driver and checked by an independent monitor on the falling edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_regfile_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_valid_i = 1'b0;
    logic        rd_we_i = 1'b0;
    logic [4:0]  rd_addr_i = '0;
    logic [1:0]  wb_sel_i = '0;
    logic [31:0] alu_result_i = '0;
    logic [31:0] mem_read_data_i = '0;
    logic [31:0] pc_i = '0;
    logic [31:0] imm_i = '0;
    logic [4:0]  rs1_addr_i = '0;
    logic [4:0]  rs2_addr_i = '0;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic        commit_valid_o;
    logic [4:0]  commit_rd_o;
    logic [31:0] commit_data_o;
    logic [63:0] cycle_cnt_o;
    logic [63:0] instret_cnt_o;

    always #5 clk = ~clk;

    wb_regfile_stage dut (
        .clk             (clk),
        .rst             (rst),
        .wb_valid_i      (wb_valid_i),
        .rd_we_i         (rd_we_i),
        .rd_addr_i       (rd_addr_i),
        .wb_sel_i        (wb_sel_i),
        .alu_result_i    (alu_result_i),
        .mem_read_data_i (mem_read_data_i),
        .pc_i            (pc_i),
        .imm_i           (imm_i),
        .rs1_addr_i      (rs1_addr_i),
        .rs2_addr_i      (rs2_addr_i),
        .rs1_data_o      (rs1_data_o),
        .rs2_data_o      (rs2_data_o),
        .commit_valid_o  (commit_valid_o),
        .commit_rd_o     (commit_rd_o),
        .commit_data_o   (commit_data_o),
        .cycle_cnt_o     (cycle_cnt_o),
        .instret_cnt_o   (instret_cnt_o)
    );

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        cv;
        logic [4:0]  crd;
        logic [31:0] cdata;
        logic [63:0] cyc;
        logic [63:0] ins;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;

    // Architectural model state
    logic [31:0] arch [32];
    logic        m_pv;
    logic [4:0]  m_prd;
    logic [31:0] m_pdata;
    logic [63:0] m_cyc;
    logic [63:0] m_ins;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) arch[i] = '0;
        m_pv = 1'b0; m_prd = '0; m_pdata = '0; m_cyc = '0; m_ins = '0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus: inputs change 1ns after the edge, the expected
    // observation for this cycle is queued, then the model advances by what
    // the next edge will retire.
    task automatic step(input bit r, input bit v, input bit we, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        logic [31:0] val;
        @(posedge clk);
        #1;
        rst = r;
        wb_valid_i = v; rd_we_i = we; rd_addr_i = rd; wb_sel_i = sel;
        alu_result_i = alu; mem_read_data_i = mem; pc_i = pc; imm_i = imm;
        rs1_addr_i = a1; rs2_addr_i = a2;
        if (!r) model_reset();
        e.rs1   = (a1 == 0) ? 32'h0 : arch[a1];
        e.rs2   = (a2 == 0) ? 32'h0 : arch[a2];
        e.cv    = m_pv;
        e.crd   = m_prd;
        e.cdata = m_pdata;
`ifdef WB_PERF_CNT_EN
        e.cyc = m_cyc;
        e.ins = m_ins;
`else
        e.cyc = '0;
        e.ins = '0;
`endif
        sb_q.push_back(e);
        if (r) begin
            case (sel)
                2'b00:   val = alu;
                2'b01:   val = mem;
                2'b10:   val = 32'((64'(pc) + 64'd4) % 64'h1_0000_0000);
                default: val = imm;
            endcase
            m_pv = v && we && (rd != 0);
            if (v) begin
                m_prd = rd;
                m_pdata = val;
            end
            if (m_pv) arch[rd] = val;
            m_cyc = m_cyc + 1;
            if (v) m_ins = m_ins + 1;
        end
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        step(1, 0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, a1, a2);
    endtask

    // Monitor: every falling edge with an outstanding expectation is a
    // DUT observation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_txn++;
                chk("rs1_data",      64'(rs1_data_o),     64'(e.rs1));
                chk("rs2_data",      64'(rs2_data_o),     64'(e.rs2));
                chk("commit_valid",  64'(commit_valid_o), 64'(e.cv));
                chk("commit_rd",     64'(commit_rd_o),    64'(e.crd));
                chk("commit_data",   64'(commit_data_o),  64'(e.cdata));
                chk("cycle_cnt",     cycle_cnt_o,         e.cyc);
                chk("instret_cnt",   instret_cnt_o,       e.ins);
                $display("[TB] txn %0d rs1=%h rs2=%h cv=%0b crd=%0d cdata=%h cyc=%0d ins=%0d",
                         n_txn, rs1_data_o, rs2_data_o, commit_valid_o, commit_rd_o,
                         commit_data_o, cycle_cnt_o, instret_cnt_o);
            end
        end
    end

    initial begin
        int budget;
        model_reset();

        // Reset then read
        step(0, 0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);
        step(0, 0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);
        idle(5'd5, 5'd31);

        // ALU write, forward, then array read
        step(1, 1, 1, 5'd3, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0);
        idle(5'd3, 5'd0);
        idle(5'd3, 5'd3);

        // x0 protection
        step(1, 1, 1, 5'd0, 2'b00, 32'h12345678, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd3);

        // Source select and back-to-back writes to x7
        step(1, 1, 1, 5'd7, 2'b01, 32'h0, 32'hFFFFFF80, 32'h0, 32'h0, 5'd0, 5'd7);
        step(1, 1, 1, 5'd7, 2'b10, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h0, 5'd0, 5'd7);
        idle(5'd3, 5'd7);
        idle(5'd3, 5'd7);
        step(1, 1, 1, 5'd12, 2'b11, 32'h0, 32'h0, 32'h0, 32'hABCD0000, 5'd12, 5'd7);
        idle(5'd12, 5'd7);

        // Reset mid-operation with a pending write to x9
        step(1, 1, 1, 5'd9, 2'b00, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 5'd9, 5'd0);
        step(0, 0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd3);
        idle(5'd9, 5'd3);
        idle(5'd9, 5'd3);

        // Counter window: 10 cycles, 4 retirements (one store)
        step(0, 0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        step(1, 1, 1, 5'd1, 2'b00, 32'h11, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2);
        idle(5'd1, 5'd2);
        step(1, 1, 0, 5'd2, 2'b00, 32'h22, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2);
        idle(5'd1, 5'd2);
        step(1, 1, 1, 5'd2, 2'b11, 32'h0, 32'h0, 32'h0, 32'h33, 5'd1, 5'd2);
        idle(5'd1, 5'd2);
        step(1, 1, 1, 5'd1, 2'b10, 32'h0, 32'h0, 32'h100, 32'h0, 5'd1, 5'd2);
        idle(5'd1, 5'd2);
        idle(5'd1, 5'd2);
        idle(5'd1, 5'd2);
        idle(5'd1, 5'd2);

        // Randomized traffic, concentrated on a few registers to stress
        // forwarding and back-to-back overwrites
        for (int i = 0; i < 600; i++) begin
            bit r, v, we;
            logic [4:0] rd, a1, a2;
            r  = ($urandom_range(0, 99) != 0);
            v  = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 4) != 0);
            rd = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 7));
            step(r, v, we, rd, 2'($urandom_range(0, 3)), $urandom, $urandom,
                 ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom, $urandom, a1, a2);
        end

        // Let the monitor drain, with a bounded wait
        budget = 0;
        while (sb_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wb_regfile_stage
